filtered_bus_synchronizer: RTL

Multi-bit synchronizer that brings an asynchronous bus into the `clk` domain through a configurable-depth flop chain per bit. A stability filter then forwards the bus only after the synchronized value has held for `STABLE_CYCLES` consecutive cycles. The filter stops transient multi-bit skew from reaching the output. Used for quasi-static configuration and status buses crossing into a core clock domain, where the per-bit double-flop synchronizer alone would let incoherent intermediate values through.

---
 rtl/cdc_pkg.sv | 13 +
 rtl/bit_sync_chain.sv | 26 ++
 rtl/filtered_bus_synchronizer.sv | 100 ++++++++++
 3 files changed

// File: rtl/cdc_pkg.sv
// Shared clock-domain-crossing constants and helpers: parameter minimums and
// the stability-counter width used by the filtered bus synchronizer.
package cdc_pkg;

    localparam int CDC_MIN_STAGES = 2;
    localparam int CDC_MIN_STABLE = 1;

    // Enough bits to hold the values 0..n inclusive.
    function automatic int cdc_cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/bit_sync_chain.sv
// Single-bit synchronizer: STAGES flops in series, all held while enable is
// low and loaded with RESET_BIT on a synchronous reset.
module bit_sync_chain #(
    parameter int   STAGES    = 2,
    parameter logic RESET_BIT = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic in,
    output logic out
);

    logic [STAGES-1:0] sync_p0;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p0 <= {STAGES{RESET_BIT}};
        end else if (enable) begin
            sync_p0 <= {sync_p0[STAGES-2:0], in};
        end
    end

    assign out = sync_p0[STAGES-1];

endmodule

// File: rtl/filtered_bus_synchronizer.sv
// Per-bit synchronizer chain followed by a stability filter that only forwards
// a bus value after STABLE_CYCLES equal samples. Macro FILTERED_BUS_SYNC_CHANGE_PULSE_EN builds the 'changed' pulse flop.
module filtered_bus_synchronizer
    import cdc_pkg::*;
#(
    parameter int               WIDTH         = 8,
    parameter int               STAGES        = 2,
    parameter int               STABLE_CYCLES = 2,
    parameter logic [WIDTH-1:0] RESET_VALUE   = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out,
    output logic             valid,
    output logic             changed
);

    localparam int            CW       = cdc_cnt_width(STABLE_CYCLES);
    localparam logic [CW-1:0] STABLE_N = CW'(STABLE_CYCLES);

    if (STAGES < CDC_MIN_STAGES) begin : g_chk_stages
        $error("filtered_bus_synchronizer: STAGES must be at least %0d", CDC_MIN_STAGES);
    end
    if (STABLE_CYCLES < CDC_MIN_STABLE) begin : g_chk_stable
        $error("filtered_bus_synchronizer: STABLE_CYCLES must be at least %0d", CDC_MIN_STABLE);
    end

    // Run length never exceeds the window, so a value held forever cannot wrap.
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
        return (c >= STABLE_N) ? STABLE_N : c + CW'(1);
    endfunction

    logic [WIDTH-1:0] s_p0;
    logic [WIDTH-1:0] prev_p1;
    logic [CW-1:0]    cnt_p1;
    logic [WIDTH-1:0] out_p1;
    logic             vld_p1;
    logic [CW-1:0]    run;
    logic             load;
    logic             differs;

    // Stage 0: synchronizer chains, one per bit
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        bit_sync_chain #(
            .STAGES    (STAGES),
            .RESET_BIT (RESET_VALUE[i])
        ) u_chain (
            .clk    (clk),
            .rst    (rst),
            .enable (enable),
            .in     (in[i]),
            .out    (s_p0[i])
        );
    end

    always_comb begin
        run     = (s_p0 == prev_p1) ? sat_inc(cnt_p1) : CW'(1);
        differs = (s_p0 != out_p1);
        load    = (run == STABLE_N) && (differs || !vld_p1);
    end

    // Stage 1: stability filter and output register
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_p1 <= RESET_VALUE;
            cnt_p1  <= '0;
            out_p1  <= RESET_VALUE;
            vld_p1  <= 1'b0;
        end else if (enable) begin
            prev_p1 <= s_p0;
            cnt_p1  <= run;
            if (load) begin
                out_p1 <= s_p0;
                vld_p1 <= 1'b1;
            end
        end
    end

    assign out   = out_p1;
    assign valid = vld_p1;

`ifdef FILTERED_BUS_SYNC_CHANGE_PULSE_EN
    logic chg_p1;

    always_ff @(posedge clk) begin
        if (rst) begin
            chg_p1 <= 1'b0;
        end else begin
            chg_p1 <= enable && load && differs;
        end
    end

    assign changed = chg_p1;
`else
    assign changed = 1'b0;
`endif

endmodule
